// File: rtl/regfile_sb.sv
// regfile_sb: multi-port integer register file with a per-register busy
// scoreboard for RAW-hazard stalls. Register 0 reads as zero and has no storage.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   rs_addr/rs_data    NRD combinational read ports (data)
//   rs_busy            scoreboard bit of each addressed register
//   wr_en/addr/data    NWR synchronous write ports (highest index wins)
//   iss_en/iss_rd      issue strobe, marks destination busy
//   regs_q/busy_q      full registered state, exported every cycle
//
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data
// (and the resulting busy state) onto the read ports.

module regfile_sb #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NRD-1:0][AW-1:0]    rs_addr,
    output logic [NRD-1:0][XLEN-1:0]  rs_data,
    output logic [NRD-1:0]            rs_busy,
    input  logic [NWR-1:0]            wr_en,
    input  logic [NWR-1:0][AW-1:0]    wr_addr,
    input  logic [NWR-1:0][XLEN-1:0]  wr_data,
    input  logic                      iss_en,
    input  logic [AW-1:0]             iss_rd,
    output logic [NREG-1:0][XLEN-1:0] regs_q,
    output logic [NREG-1:0]           busy_q
);

    // Storage exists only for registers 1..NREG-1.
    logic [NREG-1:1][XLEN-1:0] regs;
    logic [NREG-1:1][XLEN-1:0] regs_d;
    logic [NREG-1:1]           busy;
    logic [NREG-1:1]           busy_d;

    // Later write ports overwrite earlier ones, so the youngest wins.
    // Issue is applied last: a new producer supersedes a landing writeback.
    always_comb begin
        regs_d = regs;
        busy_d = busy;
        for (int r = 1; r < NREG; r++) begin
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && wr_addr[k] == AW'(r)) begin
                    regs_d[r] = wr_data[k];
                    busy_d[r] = 1'b0;
                end
            end
            if (iss_en && iss_rd == AW'(r)) begin
                busy_d[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs <= '0;
            busy <= '0;
        end else begin
            regs <= regs_d;
            busy <= busy_d;
        end
    end

    assign regs_q = {regs, {XLEN{1'b0}}};
    assign busy_q = {busy, 1'b0};

    always_comb begin
        rs_data = '0;
        rs_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            rs_data[i] = regs_q[rs_addr[i]];
            rs_busy[i] = busy_q[rs_addr[i]];
`ifdef REGFILE_BYPASS_EN
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && rs_addr[i] != '0 &&
                    wr_addr[k] == rs_addr[i]) begin
                    rs_data[i] = wr_data[k];
                    rs_busy[i] = iss_en && (iss_rd == rs_addr[i]);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and randomized checks of regfile_sb against an
// array-based reference model of the register file and scoreboard.

module tb_regfile_sb;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NRD-1:0][AW-1:0]    rs_addr;
    logic [NRD-1:0][XLEN-1:0]  rs_data;
    logic [NRD-1:0]            rs_busy;
    logic [NWR-1:0]            wr_en;
    logic [NWR-1:0][AW-1:0]    wr_addr;
    logic [NWR-1:0][XLEN-1:0]  wr_data;
    logic                      iss_en;
    logic [AW-1:0]             iss_rd;
    logic [NREG-1:0][XLEN-1:0] regs_q;
    logic [NREG-1:0]           busy_q;

    regfile_sb #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)
    ) dut (
        .clk(clk), .reset(reset),
        .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_rd(iss_rd),
        .regs_q(regs_q), .busy_q(busy_q)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    logic [XLEN-1:0] m_regs [NREG];
    bit              m_busy [NREG];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: architectural arrays updated with the write/issue rules.
    always @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                m_regs[r] = '0;
                m_busy[r] = 1'b0;
            end
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && wr_addr[k] != 0) begin
                    m_regs[wr_addr[k]] = wr_data[k];
                    m_busy[wr_addr[k]] = 1'b0;
                end
            end
            if (iss_en && iss_rd != 0) m_busy[iss_rd] = 1'b1;
        end
    end

    function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
        logic [XLEN-1:0] d;
        d = (a == 0) ? '0 : m_regs[a];
`ifdef REGFILE_BYPASS_EN
        if (a != 0)
            for (int k = 0; k < NWR; k++)
                if (wr_en[k] && wr_addr[k] == a) d = wr_data[k];
`endif
        return d;
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        logic b;
        b = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_BYPASS_EN
        if (a != 0)
            for (int k = 0; k < NWR; k++)
                if (wr_en[k] && wr_addr[k] == a)
                    b = iss_en && (iss_rd == a);
`endif
        return b;
    endfunction

    // Compare process: every cycle, mid-period, inputs stable.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NRD; i++) begin
                chk($sformatf("rs_data[%0d]", i), rs_data[i],
                    exp_data(rs_addr[i]));
                chk($sformatf("rs_busy[%0d]", i), 64'(rs_busy[i]),
                    64'(exp_busy(rs_addr[i])));
            end
            for (int r = 0; r < NREG; r++) begin
                chk($sformatf("regs_q[%0d]", r), regs_q[r], m_regs[r]);
                chk($sformatf("busy_q[%0d]", r), 64'(busy_q[r]),
                    64'(m_busy[r]));
            end
        end
    end

    task automatic idle();
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        iss_en  = 1'b0;
        iss_rd  = '0;
        rs_addr = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        cyc();
        cyc();
        chk_en = 1'b1;
        reset = 1'b0;
        mid();
        chk("reset busy_q", 64'(busy_q), 64'd0);
        chk("reset regs_q5", regs_q[5], 64'd0);

        // preload r5 busy, then reset overrides a concurrent write
        wr_en[0] = 1'b1; wr_addr[0] = 5; wr_data[0] = 64'h1234;
        iss_en = 1'b1; iss_rd = 5;
        cyc();
        idle();
        mid();
        chk("preload r5", regs_q[5], 64'h1234);
        chk("preload busy5", 64'(busy_q[5]), 64'd1);
        reset = 1'b1;
        wr_en[0] = 1'b1; wr_addr[0] = 5; wr_data[0] = 64'h99;
        cyc();
        reset = 1'b0;
        idle();
        rs_addr[0] = 5;
        mid();
        chk("rst rs_data r5", rs_data[0], 64'd0);
        chk("rst busy_q all", 64'(busy_q), 64'd0);
        chk("rst regs_q5", regs_q[5], 64'd0);

        // x0 immunity
        wr_en[0] = 1'b1; wr_addr[0] = 0; wr_data[0] = 64'hDEAD;
        iss_en = 1'b1; iss_rd = 0;
        rs_addr[0] = 0;
        mid();
        chk("x0 rs_data", rs_data[0], 64'd0);
        chk("x0 rs_busy", 64'(rs_busy[0]), 64'd0);
        cyc();
        idle();
        mid();
        chk("x0 busy_q0", 64'(busy_q[0]), 64'd0);
        chk("x0 regs_q0", regs_q[0], 64'd0);

        // write conflict: youngest port wins
        wr_en = 2'b11;
        wr_addr[0] = 7; wr_data[0] = 64'h1;
        wr_addr[1] = 7; wr_data[1] = 64'h2;
        cyc();
        idle();
        mid();
        chk("conflict r7", regs_q[7], 64'h2);

        // scoreboard
        iss_en = 1'b1; iss_rd = 3;
        cyc();
        idle();
        mid();
        chk("sb issue busy3", 64'(busy_q[3]), 64'd1);
        cyc();
        wr_en[0] = 1'b1; wr_addr[0] = 3; wr_data[0] = 64'hAB;
        cyc();
        idle();
        mid();
        chk("sb wb busy3", 64'(busy_q[3]), 64'd0);
        chk("sb wb r3", regs_q[3], 64'hAB);
        wr_en[1] = 1'b1; wr_addr[1] = 3; wr_data[1] = 64'h55;
        iss_en = 1'b1; iss_rd = 3;
        cyc();
        idle();
        mid();
        chk("sb iss+wr busy3", 64'(busy_q[3]), 64'd1);
        chk("sb iss+wr r3", regs_q[3], 64'h55);

        // bypass behaviour on r9
        wr_en[0] = 1'b1; wr_addr[0] = 9; wr_data[0] = 64'h10;
        iss_en = 1'b1; iss_rd = 9;
        cyc();
        idle();
        wr_en[0] = 1'b1; wr_addr[0] = 9; wr_data[0] = 64'h20;
        rs_addr[0] = 9;
        mid();
`ifdef REGFILE_BYPASS_EN
        chk("byp rs_data", rs_data[0], 64'h20);
        chk("byp rs_busy", 64'(rs_busy[0]), 64'd0);
`else
        chk("nobyp rs_data", rs_data[0], 64'h10);
        chk("nobyp rs_busy", 64'(rs_busy[0]), 64'd1);
`endif
        cyc();
        idle();
        rs_addr[0] = 9;
        mid();
        chk("byp next rs_data", rs_data[0], 64'h20);
        chk("byp next rs_busy", 64'(rs_busy[0]), 64'd0);

        // randomized traffic, small address pool to force collisions
        for (int n = 0; n < 2000; n++) begin
            cyc();
            reset = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < NWR; k++) begin
                wr_en[k] = 1'($urandom_range(0, 1));
                wr_addr[k] = ($urandom_range(0, 1) == 0) ?
                    AW'($urandom_range(0, 3)) : AW'($urandom);
                wr_data[k] = {$urandom, $urandom};
            end
            iss_en = ($urandom_range(0, 2) == 0);
            iss_rd = ($urandom_range(0, 1) == 0) ?
                AW'($urandom_range(0, 3)) : AW'($urandom);
            for (int i = 0; i < NRD; i++)
                rs_addr[i] = ($urandom_range(0, 1) == 0) ?
                    AW'($urandom_range(0, 3)) : AW'($urandom);
        end
        cyc();
        reset = 1'b0;
        idle();
        mid();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
